// File: rtl/seq_signed_accumulator_pkg.sv
// ============================================================================
// Module      : seq_signed_accumulator_pkg
// Description : Shared state encoding and saturation-mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_signed_accumulator_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_signed_accumulator_adder.sv
// ============================================================================
// Module      : nbit_signed_adder
// Description : WIDTH-bit two's-complement adder with signed overflow and carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nbit_signed_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             cout
);

    logic [WIDTH:0] full_w;

    assign full_w   = {1'b0, a} + {1'b0, b};
    assign sum      = full_w[WIDTH-1:0];
    assign cout     = full_w[WIDTH];
    // Signed overflow: like-signed operands producing a differently-signed sum.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (full_w[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/seq_signed_accumulator.sv
// ============================================================================
// Module      : seq_signed_accumulator
// Description : Batch accumulator of COUNT signed operands with sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_signed_accumulator
    import seq_signed_accumulator_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q;
    logic [CW-1:0]     count_q;
    logic              ovf_q, cout_q;

    logic [WIDTH-1:0]  sum_w, next_acc_w;
    logic              add_ovf_w, add_cout_w, accept_w;

    nbit_signed_adder #(.WIDTH(WIDTH)) u_adder (
        .a        (acc_q),
        .b        (in_data),
        .sum      (sum_w),
        .overflow (add_ovf_w),
        .cout     (add_cout_w)
    );

    generate
        if (SAT == SAT_CLAMP) begin : g_sat_clamp
            assign next_acc_w = !add_ovf_w   ? sum_w    :
                                acc_q[WIDTH-1] ? MOST_NEG : MOST_POS;
        end else begin : g_sat_wrap
            assign next_acc_w = sum_w;
        end
    endgenerate

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign accept_w  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (accept_w && (count_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                acc_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
                cout_q  <= 1'b0;
            end else if (accept_w) begin
                acc_q   <= next_acc_w;
                count_q <= count_q + 1'b1;
                ovf_q   <= ovf_q | add_ovf_w;
                cout_q  <= cout_q | add_cout_w;
            end
        end
    end

    assign result   = acc_q;
    assign overflow = ovf_q;
    assign cout     = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_accumulator.sv
// ============================================================================
// Module      : tb_seq_signed_accumulator
// Description : Directed bench driving wrap and saturating instances in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_signed_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       out_ready = 1'b0;

    logic       ir_w, ov_w, ovf_w, co_w, bz_w;
    logic [3:0] res_w;
    logic       ir_s, ov_s, ovf_s, co_s, bz_s;
    logic [3:0] res_s;

    int cmp_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    seq_signed_accumulator #(.WIDTH(4), .COUNT(4), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(ir_w), .out_valid(ov_w), .out_ready(out_ready),
        .result(res_w), .overflow(ovf_w), .cout(co_w), .busy(bz_w)
    );

    seq_signed_accumulator #(.WIDTH(4), .COUNT(4), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(ir_s), .out_valid(ov_s), .out_ready(out_ready),
        .result(res_s), .overflow(ovf_s), .cout(co_s), .busy(bz_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        cmp_count++;
        if ({ov_w, ir_w, bz_w, ovf_w, co_w, res_w} !== 9'd0) begin
            err_count++;
            $display("FAIL reset_wrap: got %b required 000000000", {ov_w, ir_w, bz_w, ovf_w, co_w, res_w});
        end
        cmp_count++;
        if ({ov_s, ir_s, bz_s, ovf_s, co_s, res_s} !== 9'd0) begin
            err_count++;
            $display("FAIL reset_sat: got %b required 000000000", {ov_s, ir_s, bz_s, ovf_s, co_s, res_s});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sums();
        logic [3:0] ops [4][4];
        logic [3:0] exp_w [4];
        logic [3:0] exp_s [4];
        logic       exp_o [4];
        logic       exp_c [4];
        ops[0] = '{4'd2, 4'd3, 4'd1, 4'd1};
        ops[1] = '{4'd7, 4'd5, 4'd0, 4'd0};
        ops[2] = '{4'b1101, 4'b1011, 4'd1, 4'd0};
        ops[3] = '{4'b1001, 4'b1001, 4'd0, 4'd0};
        exp_w  = '{4'b0111, 4'b1100, 4'b1001, 4'b0010};
        exp_s  = '{4'b0111, 4'b0111, 4'b1001, 4'b1000};
        exp_o  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_c  = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int v = 0; v < 4; v++) begin
            do_start();
            cmp_count++;
            if ({ir_w, ir_s, bz_w, bz_s} !== 4'b1111) begin
                err_count++;
                $display("FAIL accum_entry[%0d]: in_ready/busy got %b required 1111", v, {ir_w, ir_s, bz_w, bz_s});
            end
            for (int k = 0; k < 4; k++) begin
                feed(ops[v][k]);
                if (k == 2) begin
                    cmp_count++;
                    if ({ov_w, ov_s} !== 2'b00) begin
                        err_count++;
                        $display("FAIL early_valid[%0d]: got %b required 00", v, {ov_w, ov_s});
                    end
                end
            end
            cmp_count++;
            if ({ov_w, ov_s, ir_w, ir_s} !== 4'b1100) begin
                err_count++;
                $display("FAIL done_valid[%0d]: out_valid/in_ready got %b required 1100", v, {ov_w, ov_s, ir_w, ir_s});
            end
            cmp_count++;
            if ({res_w, ovf_w, co_w} !== {exp_w[v], exp_o[v], exp_c[v]}) begin
                err_count++;
                $display("FAIL wrap_result[%0d]: got %b/%b/%b required %b/%b/%b",
                         v, res_w, ovf_w, co_w, exp_w[v], exp_o[v], exp_c[v]);
            end
            cmp_count++;
            if ({res_s, ovf_s, co_s} !== {exp_s[v], exp_o[v], exp_c[v]}) begin
                err_count++;
                $display("FAIL sat_result[%0d]: got %b/%b/%b required %b/%b/%b",
                         v, res_s, ovf_s, co_s, exp_s[v], exp_o[v], exp_c[v]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            cmp_count++;
            if ({ov_w, ov_s, bz_w, bz_s, res_w, res_s} !== {4'b0000, exp_w[v], exp_s[v]}) begin
                err_count++;
                $display("FAIL idle_hold[%0d]: got %b required %b",
                         v, {ov_w, ov_s, bz_w, bz_s, res_w, res_s}, {4'b0000, exp_w[v], exp_s[v]});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        feed(4'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(4'd2);
        tick();
        tick();
        feed(4'd3);
        cmp_count++;
        if ({ov_w, ir_w, bz_w} !== 3'b011) begin
            err_count++;
            $display("FAIL bp_stall: out_valid/in_ready/busy got %b required 011", {ov_w, ir_w, bz_w});
        end
        feed(4'd1);
        for (int i = 0; i < 5; i++) begin
            cmp_count++;
            if ({ov_w, ov_s, res_w, res_s, ovf_w, co_w, ovf_s, co_s} !== {2'b11, 4'b0111, 4'b0111, 4'b0000}) begin
                err_count++;
                $display("FAIL bp_hold[%0d]: got %b required 110111011100 00",
                         i, {ov_w, ov_s, res_w, res_s, ovf_w, co_w, ovf_s, co_s});
            end
            tick();
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        cmp_count++;
        if ({ov_w, bz_w, ir_w, ov_s, bz_s} !== 5'b00000) begin
            err_count++;
            $display("FAIL bp_release: out_valid/busy/in_ready got %b required 00000", {ov_w, bz_w, ir_w, ov_s, bz_s});
        end
        tick();
        cmp_count++;
        if ({bz_w, res_w} !== {1'b0, 4'b0111}) begin
            err_count++;
            $display("FAIL bp_start_ignored: busy/result got %b required 00111", {bz_w, res_w});
        end
    endtask

    task automatic test_reset_mid_batch();
        do_start();
        feed(4'd5);
        feed(4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        cmp_count++;
        if ({ov_w, ir_w, bz_w, ovf_w, co_w, res_w, ov_s, ir_s, bz_s, ovf_s, co_s, res_s} !== 18'd0) begin
            err_count++;
            $display("FAIL mid_reset: got %b required all zero",
                     {ov_w, ir_w, bz_w, ovf_w, co_w, res_w, ov_s, ir_s, bz_s, ovf_s, co_s, res_s});
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        feed(4'd1);
        feed(4'd2);
        feed(4'b1111);
        feed(4'd3);
        cmp_count++;
        if ({ov_w, res_w, ovf_w, co_w} !== {1'b1, 4'b0101, 1'b0, 1'b1}) begin
            err_count++;
            $display("FAIL fresh_wrap: got %b required 1010101", {ov_w, res_w, ovf_w, co_w});
        end
        cmp_count++;
        if ({ov_s, res_s, ovf_s, co_s} !== {1'b1, 4'b0101, 1'b0, 1'b1}) begin
            err_count++;
            $display("FAIL fresh_sat: got %b required 1010101", {ov_s, res_s, ovf_s, co_s});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sums();
        test_back_to_back();
        test_reset_mid_batch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_signed_accumulator.md
Name: seq_signed_accumulator

Overview:
- Downstream consumer of the 4-bit two's-complement adder stage.
- Accepts a batch of COUNT signed operands over a valid/ready handshake and accumulates them with a WIDTH-bit signed add.
- Tracks sticky signed-overflow and carry-out flags across the batch and presents the final sum through an output valid/ready handshake.
- Optional saturation replaces wrap-around on signed overflow.

Parameters:
- WIDTH, 4, operand/accumulator width in bits (two's complement).
- COUNT, 4, operands per batch; must be >= 1.
- SAT, 0, 0 = wrap on overflow; 1 = clamp to most-positive/most-negative value.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new batch; sampled only in IDLE.
- in_valid  input  1  in_data holds a valid operand.
- in_data  input  WIDTH  signed operand.
- in_ready  output  1  block will accept an operand this cycle.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  accumulated signed sum.
- overflow  output  1  sticky: any add in the batch overflowed (signed).
- cout  output  1  sticky: any add in the batch produced a carry out of the MSB.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, acc=0, count=0, overflow=0, cout=0, out_valid=0, in_ready=0, busy=0. Reset mid-batch aborts the batch; no partial result is presented.
- FSM has three states:
  - IDLE: start=1 -> ACCUM. On that edge, clear acc, count, overflow and cout.
  - ACCUM: in_ready=1. An accept is a cycle with in_valid && in_ready. On each accept edge, acc <= next_acc and count <= count+1. If count==COUNT-1 on an accept, go to DONE.
  - DONE: out_valid=1, in_ready=0. If out_ready=1, go to IDLE and drop out_valid the next cycle.
- Add rule: {c, s} = acc + in_data as a WIDTH+1-bit unsigned add.
  - ovf_i = (acc[MSB]==in_data[MSB]) && (s[MSB]!=acc[MSB]).
  - overflow <= overflow | ovf_i; cout <= cout | c.
- next_acc:
  - SAT=0: next_acc = s.
  - SAT=1 and ovf_i=1: next_acc = most-negative if acc[MSB]=1, else most-positive.
  - Flags are computed from the raw add in both modes.
- Latency: out_valid rises the cycle after the COUNT-th accept. in_valid idle cycles (in_valid=0) stall with no state change.
- out_valid stays high and result/flags stay stable until out_ready=1. result/overflow/cout keep their values in IDLE until the next start.
- start outside IDLE is ignored. A start in the same cycle as the DONE->IDLE handshake is ignored; start is acted on only when state is IDLE.
- Counter width is $clog2(COUNT+1); no wrap possible.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2;
  - SAT mode constants.
- One sub-module, nbit_signed_adder (WIDTH-parameterised; inputs a, b; outputs sum, overflow, cout), which matches the existing four_bit_adder contract at WIDTH=4.
- FSM, counter and sticky flags stay in the top module.

Test Plan:
- SAT=0, start, operands 2,3,1,1 with in_valid held high -> out_valid 1 cycle after 4th accept; result=0111, overflow=0, cout=0.
- SAT=0, operands 7,5,0,0 -> result=1100, overflow=1, cout=0. Same run with SAT=1 -> result=0111, overflow=1.
- SAT=0, operands -3(1101),-5(1011),1,0 -> result=1001, overflow=0, cout=1.
- SAT=0, operands -7,-7,0,0 -> result=0010, overflow=1, cout=1. Same with SAT=1 -> result=1000.
- Backpressure: insert in_valid=0 gaps between operands and hold out_ready=0 for 5 cycles in DONE -> result/flags stable, out_valid held, IDLE reached the cycle after out_ready=1. A start pulsed during ACCUM is ignored.
- Drop rst_n mid-batch after 2 accepts -> all outputs immediately 0, state IDLE. A new start then yields the correct sum of a fresh 4-operand batch.
